// File: rtl/nco_ctrl_pkg.sv
// Shared types and default widths for the frequency-hopping NCO controller.
// The optional NCO_PHASE_RST_EN build macro is consumed by nco_hop_ctrl.
package nco_ctrl_pkg;

    localparam int FCW_W   = 32;
    localparam int DWELL_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DWELL = 2'd2
    } state_t;

endpackage

// File: rtl/nco_hop_table.sv
// Hop table: one synchronous write port, one asynchronous read port of {fcw, dwell}.
// Contents are deliberately not reset so a controller reset keeps the programmed plan.
module nco_hop_table #(
    parameter int  NUM_HOPS = 8,
    parameter int  FCW_W    = 32,
    parameter int  DWELL_W  = 16,
    localparam int IDX_W    = (NUM_HOPS > 1) ? $clog2(NUM_HOPS) : 1,
    localparam int ENT_W    = FCW_W + DWELL_W
) (
    input  logic               clk,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [FCW_W-1:0]   wfcw,
    input  logic [DWELL_W-1:0] wdwell,
    input  logic [IDX_W-1:0]   raddr,
    output logic [FCW_W-1:0]   rfcw,
    output logic [DWELL_W-1:0] rdwell
);

    logic [ENT_W-1:0] entry_vec [NUM_HOPS];
    logic [ENT_W-1:0] rd_entry;

    generate
        for (genvar gi = 0; gi < NUM_HOPS; gi++) begin : g_entry
            logic [ENT_W-1:0] entry_reg;

            // Addresses beyond the table depth match no entry and are dropped.
            always_ff @(posedge clk) begin
                if (we && (waddr == IDX_W'(gi))) begin
                    entry_reg <= {wfcw, wdwell};
                end
            end

            assign entry_vec[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        rd_entry = '0;
        if (int'(raddr) < NUM_HOPS) begin
            rd_entry = entry_vec[raddr];
        end
    end

    assign rfcw   = rd_entry[ENT_W-1:DWELL_W];
    assign rdwell = rd_entry[DWELL_W-1:0];

endmodule

// File: rtl/nco_hop_ctrl.sv
// Frequency-hop sequencer: walks the hop table, handing each FCW to the NCO and dwelling.
// Define NCO_PHASE_RST_EN to pulse nco_phase_rst on every accepted load.
module nco_hop_ctrl #(
    parameter int  NUM_HOPS = 8,
    parameter int  FCW_W    = nco_ctrl_pkg::FCW_W,
    parameter int  DWELL_W  = nco_ctrl_pkg::DWELL_W,
    localparam int IDX_W    = (NUM_HOPS > 1) ? $clog2(NUM_HOPS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [IDX_W-1:0]   num_hops_m1,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [FCW_W-1:0]   cfg_fcw,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [FCW_W-1:0]   nco_fcw,
    output logic               nco_load,
    input  logic               nco_ack,
    output logic               nco_en,
    output logic               nco_phase_rst,
    output logic               busy,
    output logic [IDX_W-1:0]   hop_idx,
    output logic               done
);

    import nco_ctrl_pkg::*;

    localparam logic [IDX_W-1:0] LAST_MAX = IDX_W'(NUM_HOPS - 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   hop_idx_reg, hop_idx_next;
    logic [IDX_W-1:0]   last_reg, last_next;
    logic [DWELL_W-1:0] dwell_reg, dwell_next;
    logic               nco_en_reg, nco_en_next;
    logic               done_reg, done_next;

    logic [FCW_W-1:0]   tbl_fcw;
    logic [DWELL_W-1:0] tbl_dwell;
    logic               accept;

    nco_hop_table #(
        .NUM_HOPS (NUM_HOPS),
        .FCW_W    (FCW_W),
        .DWELL_W  (DWELL_W)
    ) u_table (
        .clk    (clk),
        .we     (cfg_we && !busy),
        .waddr  (cfg_addr),
        .wfcw   (cfg_fcw),
        .wdwell (cfg_dwell),
        .raddr  (hop_idx_reg),
        .rfcw   (tbl_fcw),
        .rdwell (tbl_dwell)
    );

    // An abort in the same cycle means the NCO never really took the word.
    assign accept = (state_reg == S_LOAD) && nco_ack && !stop && !rst;

    always_comb begin
        state_next   = state_reg;
        hop_idx_next = hop_idx_reg;
        last_next    = last_reg;
        dwell_next   = dwell_reg;
        nco_en_next  = nco_en_reg;
        done_next    = 1'b0;

        if (stop) begin
            state_next  = S_IDLE;
            nco_en_next = 1'b0;
            dwell_next  = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_next   = S_LOAD;
                        hop_idx_next = '0;
                        last_next    = (num_hops_m1 > LAST_MAX) ? LAST_MAX : num_hops_m1;
                    end
                end
                S_LOAD: begin
                    if (nco_ack) begin
                        state_next  = S_DWELL;
                        nco_en_next = 1'b1;
                        dwell_next  = (tbl_dwell == '0) ? DWELL_W'(1) : tbl_dwell;
                    end
                end
                S_DWELL: begin
                    if (dwell_reg <= DWELL_W'(1)) begin
                        dwell_next = '0;
                        if (hop_idx_reg < last_reg) begin
                            state_next   = S_LOAD;
                            hop_idx_next = hop_idx_reg + 1'b1;
                        end else if (loop_en) begin
                            state_next   = S_LOAD;
                            hop_idx_next = '0;
                        end else begin
                            state_next  = S_IDLE;
                            nco_en_next = 1'b0;
                            done_next   = 1'b1;
                        end
                    end else begin
                        dwell_next = dwell_reg - 1'b1;
                    end
                end
                default: begin
                    state_next  = S_IDLE;
                    nco_en_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            hop_idx_reg <= '0;
            last_reg    <= '0;
            dwell_reg   <= '0;
            nco_en_reg  <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hop_idx_reg <= hop_idx_next;
            last_reg    <= last_next;
            dwell_reg   <= dwell_next;
            nco_en_reg  <= nco_en_next;
            done_reg    <= done_next;
        end
    end

    // The table is write-locked while busy, so its read data is stable for the whole hop.
    assign busy     = (state_reg != S_IDLE);
    assign nco_load = (state_reg == S_LOAD);
    assign nco_fcw  = busy ? tbl_fcw : '0;
    assign nco_en   = nco_en_reg;
    assign hop_idx  = hop_idx_reg;
    assign done     = done_reg;

`ifdef NCO_PHASE_RST_EN
    assign nco_phase_rst = accept;
`else
    assign nco_phase_rst = 1'b0;
`endif

endmodule

// File: tb/tb_nco_hop_ctrl.sv
// Randomized scoreboard bench for nco_hop_ctrl; a hop-level model predicts every
// completed hop (fcw, index, dwell length) and every done pulse.
module tb_nco_hop_ctrl;

    localparam int NH = 6;
    localparam int FW = 32;
    localparam int DW = 16;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst, start, stop, loop_en, cfg_we;
    logic          nco_ack = 1'b0;
    logic [IW-1:0] num_hops_m1, cfg_addr;
    logic [FW-1:0] cfg_fcw;
    logic [DW-1:0] cfg_dwell;
    logic [FW-1:0] nco_fcw;
    logic          nco_load, nco_en, nco_phase_rst, busy, done;
    logic [IW-1:0] hop_idx;

    always #5 clk = ~clk;

    nco_hop_ctrl #(.NUM_HOPS(NH), .FCW_W(FW), .DWELL_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .loop_en       (loop_en),
        .num_hops_m1   (num_hops_m1),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_fcw       (cfg_fcw),
        .cfg_dwell     (cfg_dwell),
        .nco_fcw       (nco_fcw),
        .nco_load      (nco_load),
        .nco_ack       (nco_ack),
        .nco_en        (nco_en),
        .nco_phase_rst (nco_phase_rst),
        .busy          (busy),
        .hop_idx       (hop_idx),
        .done          (done)
    );

    typedef struct {
        int          kind;   // 0 = completed hop, 1 = done pulse
        logic [FW-1:0] fcw;
        int          idx;
        int          dwell;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            total = 0;
    int            bad = 0;
    int            hops_done = 0;
    int            ack_mode = 1;   // 0 random, 1 always, 2 never
    logic [FW-1:0] m_fcw [NH];
    int            m_dwell [NH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0:       nco_ack = ($urandom_range(0, 2) != 0);
            2:       nco_ack = 1'b0;
            default: nco_ack = 1'b1;
        endcase
    end

    // Monitor: assembles hop transactions from the DUT pins and checks them against the queue.
    logic          in_hop = 1'b0, seq_active = 1'b0, en_bad = 1'b0;
    logic          pv_load = 1'b0, pv_ack = 1'b0, pv_stop = 1'b0, pv_rst = 1'b1;
    logic [FW-1:0] pv_fcw = '0, cap_fcw = '0;
    int            cap_idx = 0, cnt = 0;

    always @(negedge clk) begin
`ifdef NCO_PHASE_RST_EN
        chk("phase_rst", nco_phase_rst, nco_load && nco_ack && !stop && !rst);
`else
        chk("phase_rst", nco_phase_rst, 0);
`endif
        if (pv_load && !pv_ack && !pv_stop && !pv_rst) begin
            chk("load_hold", nco_load, 1);
            chk("fcw_hold", nco_fcw, pv_fcw);
        end
        pv_load = nco_load; pv_ack = nco_ack; pv_stop = stop; pv_rst = rst; pv_fcw = nco_fcw;

        if (rst) begin
            in_hop = 1'b0;
            seq_active = 1'b0;
        end else begin
            if (in_hop) begin
                if (busy && !nco_load) begin
                    cnt++;
                    if (!nco_en) en_bad = 1'b1;
                end else begin
                    in_hop = 1'b0;
                    hops_done++;
                    $display("hop idx=%0d fcw=%h dwell=%0d", cap_idx, cap_fcw, cnt);
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL hop_unexpected: got idx=%0d want none", cap_idx);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("hop_kind", 0, mon_e.kind);
                        chk("hop_fcw", cap_fcw, mon_e.fcw);
                        chk("hop_idx", cap_idx, mon_e.idx);
                        chk("hop_dwell", cnt, mon_e.dwell);
                        chk("dwell_en", en_bad, 0);
                    end
                    seq_active = nco_load;
                end
            end
            if (done) begin
                $display("done busy=%0d nco_en=%0d", busy, nco_en);
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected: got done want none");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_kind", 1, mon_e.kind);
                    chk("done_en", nco_en, 0);
                    chk("done_busy", busy, 0);
                end
            end
            if (!busy) seq_active = 1'b0;
            if (stop) begin
                in_hop = 1'b0;
                seq_active = 1'b0;
            end else if (nco_load && nco_ack) begin
                chk("load_en", nco_en, seq_active);
                in_hop = 1'b1;
                cap_fcw = nco_fcw;
                cap_idx = int'(hop_idx);
                cnt = 0;
                en_bad = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [FW-1:0] f, input int d, input bit model);
        cfg_we = 1'b1; cfg_addr = IW'(a); cfg_fcw = f; cfg_dwell = DW'(d);
        tick();
        cfg_we = 1'b0;
        if (model && a < NH) begin
            m_fcw[a] = f;
            m_dwell[a] = d;
        end
    endtask

    function automatic int last_of(input int m1);
        return (m1 > NH - 1) ? NH - 1 : m1;
    endfunction

    task automatic expect_hops(input int m1, input int count, input bit with_done);
        int n;
        n = last_of(m1) + 1;
        for (int i = 0; i < count; i++) begin
            exp_t e;
            e.kind = 0;
            e.idx = i % n;
            e.fcw = m_fcw[e.idx];
            e.dwell = (m_dwell[e.idx] == 0) ? 1 : m_dwell[e.idx];
            exp_q.push_back(e);
        end
        if (with_done) begin
            exp_t e;
            e.kind = 1; e.idx = 0; e.fcw = '0; e.dwell = 0;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 3000) begin
            tick();
            guard++;
        end
        chk("idle_timeout", guard < 3000, 1);
        tick();
        tick();
    endtask

    task automatic run_seq(input int m1, input bit lp, input int k);
        int base, guard;
        base = hops_done;
        guard = 0;
        expect_hops(m1, lp ? k : last_of(m1) + 1, !lp);
        num_hops_m1 = IW'(m1); loop_en = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (lp) begin
            while ((hops_done - base) < k && guard < 3000) begin
                tick();
                guard++;
            end
            chk("loop_timeout", guard < 3000, 1);
            stop = 1'b1;
            tick();
            stop = 1'b0;
            chk("stop_busy", busy, 0);
            chk("stop_en", nco_en, 0);
            chk("stop_load", nco_load, 0);
            tick();
        end else begin
            while (busy && guard < 3000) begin
                // start in LOAD can never coincide with a return to idle, so it must be ignored
                start = nco_load && ($urandom_range(0, 3) == 0);
                tick();
                start = 1'b0;
                guard++;
            end
            chk("seq_timeout", guard < 3000, 1);
            tick();
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_fcw = '0; cfg_dwell = '0; num_hops_m1 = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_load", nco_load, 0);
        chk("rst_en", nco_en, 0);
        chk("rst_fcw", nco_fcw, 0);
        chk("rst_idx", hop_idx, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // Two-hop one-shot plan with ack always high.
        wr(0, 32'h1000, 3, 1);
        wr(1, 32'h2000, 2, 1);
        ack_mode = 1;
        run_seq(1, 0, 0);

        // NCO stalls the load for four cycles.
        ack_mode = 2;
        expect_hops(0, 1, 1);
        num_hops_m1 = '0; loop_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) begin
            chk("stall_load", nco_load, 1);
            chk("stall_fcw", nco_fcw, 32'h1000);
            tick();
        end
        ack_mode = 1;
        wait_idle();

        // Looping two-hop plan, stopped after four hops.
        ack_mode = 0;
        run_seq(1, 1, 4);

        // Zero dwell behaves as one cycle; start together with stop stays idle.
        wr(2, 32'h3000, 0, 1);
        run_seq(2, 0, 0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 0);
        chk("startstop_load", nco_load, 0);
        tick();

        // Write attempted while busy must not land.
        ack_mode = 2;
        expect_hops(1, 2, 1);
        num_hops_m1 = IW'(1); loop_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr(0, 32'hDEAD, 5, 0);
        ack_mode = 1;
        wait_idle();
        run_seq(1, 0, 0);

        // Reset in the middle of a dwell, then check the table survived.
        ack_mode = 1;
        num_hops_m1 = IW'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!(busy && !nco_load) && guard < 100) begin
            tick();
            guard++;
        end
        chk("reach_dwell", busy && !nco_load, 1);
        rst = 1'b1;
        tick();
        chk("mrst_busy", busy, 0);
        chk("mrst_load", nco_load, 0);
        chk("mrst_en", nco_en, 0);
        chk("mrst_fcw", nco_fcw, 0);
        chk("mrst_idx", hop_idx, 0);
        chk("mrst_done", done, 0);
        chk("mrst_prst", nco_phase_rst, 0);
        rst = 1'b0;
        tick();
        run_seq(1, 0, 0);

        // Random plans, including clamped hop counts and out-of-range writes.
        for (int r = 0; r < 12; r++) begin
            int m1, k;
            bit lp;
            for (int a = 0; a < NH; a++) wr(a, $urandom, $urandom_range(0, 5), 1);
            wr(7, $urandom, 1, 1);
            ack_mode = 0;
            m1 = $urandom_range(0, 7);
            lp = 1'($urandom_range(0, 1));
            k = $urandom_range(1, 8);
            run_seq(m1, lp, k);
        end

        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nco_hop_ctrl.md
NCO_HOP_CTRL -- requirements
Module: nco_hop_ctrl

Interface
REQ-001 SHALL have parameter NUM_HOPS, default 8, meaning hop-table depth.
REQ-002 SHALL have parameter FCW_W, default 32, meaning frequency control word width.
REQ-003 SHALL have parameter DWELL_W, default 16, meaning dwell counter width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-005 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-006 SHALL have port start, input, 1, meaning a sequence start request.
REQ-007 SHALL have port stop, input, 1, meaning an abort request.
REQ-008 SHALL have port loop_en, input, 1, meaning wrap to hop 0 after the last hop.
REQ-009 SHALL have port num_hops_m1, input, $clog2(NUM_HOPS), meaning last hop index used.
REQ-010 SHALL have ports cfg_we (input, 1), cfg_addr (input, $clog2(NUM_HOPS)), cfg_fcw (input, FCW_W) and cfg_dwell (input, DWELL_W), forming the hop-table write port.
REQ-011 SHALL have ports nco_fcw (output, FCW_W) and nco_load (output, 1), meaning the FCW offered to the NCO, valid-qualified.
REQ-012 SHALL have port nco_ack, input, 1, meaning the NCO accepts the load.
REQ-013 SHALL have ports nco_en (output, 1) and nco_phase_rst (output, 1), meaning NCO run enable and phase-accumulator clear.
REQ-014 SHALL have ports busy (output, 1), hop_idx (output, $clog2(NUM_HOPS)) and done (output, 1), meaning status and the current hop index.

Function
REQ-015 FSM states SHALL be IDLE, LOAD and DWELL.
REQ-016 IDLE->LOAD SHALL occur on start=1 and stop=0, with hop_idx set to 0; nco_load=1 in the cycle after start.
REQ-017 In LOAD, nco_load SHALL be 1 and nco_fcw SHALL equal table[hop_idx], held stable until nco_ack=1 (valid/ready; acceptance occurs when nco_load and nco_ack are both 1).
REQ-018 On acceptance, the FSM SHALL move LOAD->DWELL, set nco_en=1, and load the dwell counter with max(table_dwell[hop_idx],1).
REQ-019 DWELL SHALL last exactly that many cycles; a dwell value of 0 SHALL be treated as 1.
REQ-020 At dwell end with hop_idx<num_hops_m1, the FSM SHALL increment hop_idx and enter LOAD.
REQ-021 At dwell end with hop_idx==num_hops_m1 and loop_en=1, hop_idx SHALL wrap to 0 and the FSM SHALL enter LOAD.
REQ-022 At dwell end with hop_idx==num_hops_m1 and loop_en=0, the FSM SHALL enter IDLE, pulse done for 1 cycle and clear nco_en.
REQ-023 nco_en SHALL remain 1 through LOAD states between hops, so the NCO keeps its previous FCW until the new one is accepted.
REQ-024 stop=1 in any state SHALL force IDLE next cycle, with nco_en=0, nco_load=0 and no done pulse; stop SHALL win over a simultaneous start.
REQ-025 start SHALL be ignored while busy.
REQ-026 busy SHALL be 1 exactly when the state is not IDLE.
REQ-027 A cfg_we write SHALL update the table entry the next cycle when busy=0 and SHALL be ignored while busy=1.
REQ-028 num_hops_m1 values greater than NUM_HOPS-1 SHALL be clamped to NUM_HOPS-1, sampled at start.

Reset
REQ-029 rst=1 SHALL force IDLE, hop_idx=0, dwell counter=0, and all outputs 0 (nco_fcw=0) on the next edge, including mid-sequence.
REQ-030 Reset SHALL NOT clear the hop-table contents; table contents are undefined after power-up until written.

Configuration
REQ-031 With NCO_PHASE_RST_EN defined, nco_phase_rst SHALL pulse for 1 cycle coincident with each accepted load.
REQ-032 Without NCO_PHASE_RST_EN, nco_phase_rst SHALL be tied to 0 and the phase-continuous hop is the only mode.

Structure
REQ-033 Package nco_ctrl_pkg SHALL hold the state enum type and default width constants (FCW_W, DWELL_W).
REQ-034 One sub-module, nco_hop_table (dual-use register array: one write port, one asynchronous read port of {fcw, dwell}), SHALL hold the table.

Verification
REQ-035 Table {0:0x1000/3, 1:0x2000/2}, num_hops_m1=1, loop_en=0, nco_ack=1 held -> fcw 0x1000 for 3 cycles, then 0x2000 for 2 cycles, done pulse, nco_en=0.
REQ-036 nco_ack held 0 for 4 cycles in LOAD -> nco_load=1 and nco_fcw stable throughout; DWELL starts the cycle after ack.
REQ-037 loop_en=1, 2 hops -> hop_idx sequence 0,1,0,1 with no done; then stop -> IDLE next cycle, nco_en=0.
REQ-038 Dwell=0 entry -> 1-cycle DWELL; start and stop asserted in the same cycle -> stays IDLE.
REQ-039 rst asserted mid-DWELL -> all outputs 0 next cycle; a cfg_we write while busy -> table unchanged (read back after idle).
REQ-040 With NCO_PHASE_RST_EN defined -> one nco_phase_rst pulse per accepted load; without it -> nco_phase_rst constant 0.
